// File: rtl/letter_pool_pkg.sv
// Shared types and constants for the falling-letter game: slot record, FSM states,
// ASCII bounds and screen limits used by the pool, generator and renderer.
package letter_pool_pkg;

  localparam int unsigned CH_W  = 8;
  localparam int unsigned SPD_W = 3;
  localparam int unsigned X_W   = 9;
  localparam int unsigned Y_W   = 10;

  localparam logic [CH_W-1:0] ASCII_A = 8'h41;
  localparam logic [CH_W-1:0] ASCII_Z = 8'h5A;

  localparam int unsigned SCREEN_H = 480;
  localparam int unsigned SCREEN_W = 640;

  typedef struct packed {
    logic             valid;
    logic [CH_W-1:0]  ch;
    logic [SPD_W-1:0] speed;
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
  } slot_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OVER = 2'd2
  } state_e;

endpackage

// File: rtl/letter_pool_if.sv
// Bundle between the letter pool and its neighbours: generator/key/frame inputs,
// renderer read port and score outputs.
interface letter_pool_if
  import letter_pool_pkg::*;
#(
  parameter int unsigned IDX_W = 3
);
  logic             frame_tick;
  logic             start;
  logic [CH_W-1:0]  gen_ch;
  logic [SPD_W-1:0] gen_speed;
  logic [X_W-1:0]   gen_x;
  logic [Y_W-1:0]   gen_y;
  logic             key_valid;
  logic [CH_W-1:0]  key_code;
  logic [IDX_W-1:0] rd_idx;

  logic             rd_valid;
  logic [CH_W-1:0]  rd_ch;
  logic [X_W-1:0]   rd_x;
  logic [Y_W-1:0]   rd_y;
  logic             hit_pulse;
  logic             wrong_pulse;
  logic             miss_pulse;
  logic [15:0]      hit_cnt;
  logic [7:0]       miss_cnt;
  logic             game_over;

  modport master (
    output frame_tick, start, gen_ch, gen_speed, gen_x, gen_y, key_valid, key_code, rd_idx,
    input  rd_valid, rd_ch, rd_x, rd_y, hit_pulse, wrong_pulse, miss_pulse,
           hit_cnt, miss_cnt, game_over
  );

  modport slave (
    input  frame_tick, start, gen_ch, gen_speed, gen_x, gen_y, key_valid, key_code, rd_idx,
    output rd_valid, rd_ch, rd_x, rd_y, hit_pulse, wrong_pulse, miss_pulse,
           hit_cnt, miss_cnt, game_over
  );
endinterface

// File: rtl/letter_match_sel.sv
// Picks the active slot whose letter matches the key: the one lowest on screen
// (largest x), lowest index on a tie.
module letter_match_sel
  import letter_pool_pkg::*;
#(
  parameter int unsigned N_SLOTS = 8,
  parameter int unsigned IDX_W   = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1
)(
  input  slot_t            slots_i [N_SLOTS],
  input  logic [CH_W-1:0]  key_code_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [X_W-1:0] best_x;
  logic           unused_bits;

  // Strict greater-than while scanning upward keeps the lowest index on ties.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    best_x  = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (slots_i[i].valid && (slots_i[i].ch == key_code_i) &&
          (!found_o || (slots_i[i].x > best_x))) begin
        found_o = 1'b1;
        idx_o   = IDX_W'(i);
        best_x  = slots_i[i].x;
      end
    end
  end

  always_comb begin
    unused_bits = 1'b0;
    for (int i = 0; i < N_SLOTS; i++) begin
      unused_bits = unused_bits ^ (^slots_i[i].speed) ^ (^slots_i[i].y);
    end
  end

endmodule

// File: rtl/letter_pool.sv
// Pool of falling letters: spawns from the generator, moves per frame, retires on
// key hit or bottom miss, and runs the IDLE/RUN/OVER game state.
module letter_pool
  import letter_pool_pkg::*;
#(
  parameter int unsigned    N_SLOTS      = 8,
  parameter int unsigned    SPAWN_PERIOD = 30,
  parameter logic [X_W-1:0] X_BOTTOM     = 9'd460,
  parameter int unsigned    MAX_MISS     = 10
)(
  input logic         clk,
  input logic         rst_n,
  letter_pool_if.slave bus
);

  localparam int unsigned IDX_W  = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
  localparam int unsigned CNT_W  = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
  localparam int unsigned MCNT_W = $clog2(N_SLOTS + 1);

  state_e           state_q, state_d;
  slot_t            slots_q [N_SLOTS];
  slot_t            slots_d [N_SLOTS];
  logic [CNT_W-1:0] spawn_cnt_q, spawn_cnt_d;
  logic [15:0]      hit_cnt_q, hit_cnt_d;
  logic [7:0]       miss_cnt_q, miss_cnt_d;
  logic             hit_pulse_q, hit_pulse_d;
  logic             wrong_pulse_q, wrong_pulse_d;
  logic             miss_pulse_q, miss_pulse_d;
  logic             game_over_q, game_over_d;
  logic             rd_valid_q, rd_valid_d;
  logic [CH_W-1:0]  rd_ch_q, rd_ch_d;
  logic [X_W-1:0]   rd_x_q, rd_x_d;
  logic [Y_W-1:0]   rd_y_q, rd_y_d;

  logic              key_found;
  logic [IDX_W-1:0]  key_idx;
  logic              free_found;
  logic [IDX_W-1:0]  free_idx;
  logic              hit;
  logic [X_W:0]      new_x;
  logic [MCNT_W-1:0] miss_n;
  logic [8:0]        miss_sum;

  letter_match_sel #(
    .N_SLOTS (N_SLOTS),
    .IDX_W   (IDX_W)
  ) u_match (
    .slots_i    (slots_q),
    .key_code_i (bus.key_code),
    .found_o    (key_found),
    .idx_o      (key_idx)
  );

  // Spawn target comes from start-of-cycle occupancy, so slots freed this cycle wait.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (!free_found && !slots_q[i].valid) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    slots_d       = slots_q;
    spawn_cnt_d   = spawn_cnt_q;
    hit_cnt_d     = hit_cnt_q;
    miss_cnt_d    = miss_cnt_q;
    hit_pulse_d   = 1'b0;
    wrong_pulse_d = 1'b0;
    miss_pulse_d  = 1'b0;
    hit           = 1'b0;
    new_x         = '0;
    miss_n        = '0;
    miss_sum      = '0;

    unique case (state_q)
      ST_RUN: begin
        if (32'(miss_cnt_q) >= MAX_MISS) state_d = ST_OVER;

        hit = bus.key_valid && key_found;
        hit_pulse_d   = hit;
        wrong_pulse_d = bus.key_valid && !key_found;
        if (hit && (hit_cnt_q != 16'hFFFF)) hit_cnt_d = hit_cnt_q + 16'd1;

        // Key resolves against pre-move positions; the hit slot skips the move.
        for (int i = 0; i < N_SLOTS; i++) begin
          if (hit && (key_idx == IDX_W'(i))) begin
            slots_d[i].valid = 1'b0;
          end else if (bus.frame_tick && slots_q[i].valid) begin
            new_x = (X_W+1)'(slots_q[i].x) + (X_W+1)'(slots_q[i].speed);
            if (new_x >= (X_W+1)'(X_BOTTOM)) begin
              slots_d[i].valid = 1'b0;
              miss_n = miss_n + MCNT_W'(1);
            end else begin
              slots_d[i].x = new_x[X_W-1:0];
            end
          end
        end

        miss_pulse_d = (miss_n != '0);
        miss_sum     = 9'(miss_cnt_q) + 9'(miss_n);
        miss_cnt_d   = miss_sum[8] ? 8'hFF : miss_sum[7:0];

        if (bus.frame_tick) begin
          if (spawn_cnt_q == CNT_W'(SPAWN_PERIOD - 1)) begin
            spawn_cnt_d = '0;
            if (free_found) begin
              slots_d[free_idx] = '{valid: 1'b1, ch: bus.gen_ch, speed: bus.gen_speed,
                                    x: bus.gen_x, y: bus.gen_y};
            end
          end else begin
            spawn_cnt_d = spawn_cnt_q + CNT_W'(1);
          end
        end
      end

      ST_IDLE, ST_OVER: begin
        if (bus.start) begin
          state_d     = ST_RUN;
          spawn_cnt_d = '0;
          hit_cnt_d   = '0;
          miss_cnt_d  = '0;
          for (int i = 0; i < N_SLOTS; i++) slots_d[i] = '0;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    game_over_d = (state_d == ST_OVER);
  end

  always_comb begin
    rd_valid_d = 1'b0;
    rd_ch_d    = '0;
    rd_x_d     = '0;
    rd_y_d     = '0;
    if (32'(bus.rd_idx) < N_SLOTS) begin
      rd_valid_d = slots_q[bus.rd_idx].valid;
      rd_ch_d    = slots_q[bus.rd_idx].ch;
      rd_x_d     = slots_q[bus.rd_idx].x;
      rd_y_d     = slots_q[bus.rd_idx].y;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      for (int i = 0; i < N_SLOTS; i++) slots_q[i] <= '0;
      spawn_cnt_q   <= '0;
      hit_cnt_q     <= '0;
      miss_cnt_q    <= '0;
      hit_pulse_q   <= 1'b0;
      wrong_pulse_q <= 1'b0;
      miss_pulse_q  <= 1'b0;
      game_over_q   <= 1'b0;
      rd_valid_q    <= 1'b0;
      rd_ch_q       <= '0;
      rd_x_q        <= '0;
      rd_y_q        <= '0;
    end else begin
      state_q       <= state_d;
      for (int i = 0; i < N_SLOTS; i++) slots_q[i] <= slots_d[i];
      spawn_cnt_q   <= spawn_cnt_d;
      hit_cnt_q     <= hit_cnt_d;
      miss_cnt_q    <= miss_cnt_d;
      hit_pulse_q   <= hit_pulse_d;
      wrong_pulse_q <= wrong_pulse_d;
      miss_pulse_q  <= miss_pulse_d;
      game_over_q   <= game_over_d;
      rd_valid_q    <= rd_valid_d;
      rd_ch_q       <= rd_ch_d;
      rd_x_q        <= rd_x_d;
      rd_y_q        <= rd_y_d;
    end
  end

  assign bus.rd_valid    = rd_valid_q;
  assign bus.rd_ch       = rd_ch_q;
  assign bus.rd_x        = rd_x_q;
  assign bus.rd_y        = rd_y_q;
  assign bus.hit_pulse   = hit_pulse_q;
  assign bus.wrong_pulse = wrong_pulse_q;
  assign bus.miss_pulse  = miss_pulse_q;
  assign bus.hit_cnt     = hit_cnt_q;
  assign bus.miss_cnt    = miss_cnt_q;
  assign bus.game_over   = game_over_q;

endmodule

// File: tb/tb_letter_pool.sv
// Scoreboard bench for letter_pool: stimulus queues expected pulses and slot reads,
// a negedge monitor pops and compares whenever the pool presents them.
module tb_letter_pool;
  import letter_pool_pkg::*;

  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  letter_pool_if #(.IDX_W(3)) bus ();

  letter_pool #(
    .N_SLOTS      (8),
    .SPAWN_PERIOD (2),
    .X_BOTTOM     (9'd100),
    .MAX_MISS     (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic        hit;
    logic        wrong;
    logic        miss;
    logic [15:0] hc;
    logic [7:0]  mc;
  } ev_t;

  typedef struct packed {
    logic       v;
    logic [7:0] ch;
    logic [8:0] x;
    logic [9:0] y;
  } rd_t;

  ev_t ev_q[$];
  rd_t rd_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;
  logic rd_req, rd_req_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: pulses and read-port data are checked against queued expectations.
  always @(posedge clk) rd_req_q <= rd_req;

  always @(negedge clk) begin
    ev_t e;
    rd_t r;
    if (bus.hit_pulse || bus.wrong_pulse || bus.miss_pulse) begin
      if (ev_q.size() == 0) begin
        chk("unexpected_pulse", 32'({bus.hit_pulse, bus.wrong_pulse, bus.miss_pulse}), 32'd0);
      end else begin
        e = ev_q.pop_front();
        chk("pulses", 32'({bus.hit_pulse, bus.wrong_pulse, bus.miss_pulse}),
            32'({e.hit, e.wrong, e.miss}));
        chk("ev_hit_cnt", 32'(bus.hit_cnt), 32'(e.hc));
        chk("ev_miss_cnt", 32'(bus.miss_cnt), 32'(e.mc));
      end
    end
    if (rd_req_q === 1'b1) begin
      if (rd_q.size() == 0) begin
        chk("unexpected_read", 32'd1, 32'd0);
      end else begin
        r = rd_q.pop_front();
        chk("rd_valid", 32'(bus.rd_valid), 32'(r.v));
        if (r.v) begin
          chk("rd_ch", 32'(bus.rd_ch), 32'(r.ch));
          chk("rd_x", 32'(bus.rd_x), 32'(r.x));
          chk("rd_y", 32'(bus.rd_y), 32'(r.y));
        end
      end
    end
  end

  task automatic cyc(input logic ft, input logic kv, input logic [7:0] kc);
    bus.frame_tick = ft;
    bus.key_valid  = kv;
    bus.key_code   = kc;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    bus.key_valid  = 1'b0;
  endtask

  task automatic tick();
    cyc(1'b1, 1'b0, 8'h00);
  endtask

  task automatic key(input logic [7:0] k);
    cyc(1'b0, 1'b1, k);
  endtask

  task automatic set_gen(input logic [7:0] ch, input logic [2:0] spd,
                         input logic [8:0] x, input logic [9:0] y);
    bus.gen_ch    = ch;
    bus.gen_speed = spd;
    bus.gen_x     = x;
    bus.gen_y     = y;
  endtask

  // Two frame ticks; with a spawn period of 2 the second one spawns.
  task automatic two_ticks(input logic [7:0] ch, input logic [2:0] spd,
                           input logic [8:0] x, input logic [9:0] y);
    set_gen(ch, spd, x, y);
    tick();
    tick();
  endtask

  task automatic rd_chk(input logic [2:0] idx, input logic v, input logic [7:0] ch,
                        input logic [8:0] x, input logic [9:0] y);
    rd_t r;
    r = '{v: v, ch: ch, x: x, y: y};
    rd_q.push_back(r);
    bus.rd_idx = idx;
    rd_req     = 1'b1;
    @(negedge clk);
    rd_req     = 1'b0;
  endtask

  task automatic exp_ev(input logic h, input logic w, input logic m,
                        input logic [15:0] hc, input logic [7:0] mc);
    ev_t e;
    e = '{hit: h, wrong: w, miss: m, hc: hc, mc: mc};
    ev_q.push_back(e);
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    bus.frame_tick = 1'b0;
    bus.start      = 1'b0;
    bus.key_valid  = 1'b0;
    bus.key_code   = 8'h00;
    bus.rd_idx     = 3'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic start_game();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rd_req = 1'b0;
    set_gen(8'h00, 3'd1, 9'd0, 10'd0);
    do_reset();

    // Reset state, then spawn cadence and movement.
    chk("reset_hit_cnt", 32'(bus.hit_cnt), 32'd0);
    chk("reset_miss_cnt", 32'(bus.miss_cnt), 32'd0);
    chk("reset_game_over", 32'(bus.game_over), 32'd0);
    chk("reset_rd_valid", 32'(bus.rd_valid), 32'd0);
    rd_chk(3'd0, 1'b0, 8'h00, 9'd0, 10'd0);
    set_gen("Q", 3'd2, 9'd0, 10'd90);
    start_game();
    tick();
    tick();
    rd_chk(3'd0, 1'b1, "Q", 9'd0, 10'd90);
    tick();
    rd_chk(3'd0, 1'b1, "Q", 9'd2, 10'd90);
    rd_chk(3'd1, 1'b0, 8'h00, 9'd0, 10'd0);
    tick();
    rd_chk(3'd0, 1'b1, "Q", 9'd4, 10'd90);
    rd_chk(3'd1, 1'b1, "Q", 9'd0, 10'd90);
    rd_chk(3'd2, 1'b0, 8'h00, 9'd0, 10'd0);
    chk("s1_hit_cnt", 32'(bus.hit_cnt), 32'd0);
    chk("s1_miss_cnt", 32'(bus.miss_cnt), 32'd0);

    // Bottom miss: 91 -> 94 -> 97 -> 100 retires on the third move.
    do_reset();
    start_game();
    set_gen("M", 3'd3, 9'd91, 10'd200);
    tick();
    tick();
    tick();
    tick();
    exp_ev(1'b0, 1'b0, 1'b1, 16'd0, 8'd1);
    tick();
    rd_chk(3'd0, 1'b0, 8'h00, 9'd0, 10'd0);
    rd_chk(3'd1, 1'b1, "M", 9'd94, 10'd200);
    chk("s2_game_over", 32'(bus.game_over), 32'd0);

    // Key selection: largest x wins; unmatched key is a wrong press.
    do_reset();
    start_game();
    two_ticks("B", 3'd1, 9'd0, 10'd10);
    two_ticks("C", 3'd1, 9'd0, 10'd20);
    two_ticks("A", 3'd1, 9'd24, 10'd30);
    two_ticks("C", 3'd1, 9'd0, 10'd40);
    two_ticks("B", 3'd1, 9'd0, 10'd50);
    two_ticks("A", 3'd1, 9'd60, 10'd60);
    rd_chk(3'd2, 1'b1, "A", 9'd30, 10'd30);
    rd_chk(3'd5, 1'b1, "A", 9'd60, 10'd60);
    exp_ev(1'b1, 1'b0, 1'b0, 16'd1, 8'd0);
    key("A");
    rd_chk(3'd5, 1'b0, 8'h00, 9'd0, 10'd0);
    rd_chk(3'd2, 1'b1, "A", 9'd30, 10'd30);
    start_game();
    exp_ev(1'b0, 1'b1, 1'b0, 16'd1, 8'd0);
    key("Z");
    rd_chk(3'd2, 1'b1, "A", 9'd30, 10'd30);
    rd_chk(3'd0, 1'b1, "B", 9'd10, 10'd10);
    exp_ev(1'b1, 1'b0, 1'b0, 16'd2, 8'd0);
    key("A");
    rd_chk(3'd2, 1'b0, 8'h00, 9'd0, 10'd0);

    // Key and frame tick together at X_BOTTOM-1: hit, not miss.
    do_reset();
    start_game();
    two_ticks("K", 3'd3, 9'd99, 10'd300);
    rd_chk(3'd0, 1'b1, "K", 9'd99, 10'd300);
    exp_ev(1'b1, 1'b0, 1'b0, 16'd1, 8'd0);
    cyc(1'b1, 1'b1, "K");
    rd_chk(3'd0, 1'b0, 8'h00, 9'd0, 10'd0);
    chk("s4_miss_cnt", 32'(bus.miss_cnt), 32'd0);

    // Full pool drops the spawn; the freed slot is refilled next opportunity.
    do_reset();
    start_game();
    for (int k = 0; k < 8; k++) two_ticks(8'(ASCII_A + 8'(k)), 3'd1, 9'd0, 10'(k * 10));
    tick();
    set_gen("X", 3'd1, 9'd0, 10'd0);
    exp_ev(1'b1, 1'b0, 1'b0, 16'd1, 8'd0);
    cyc(1'b1, 1'b1, "C");
    rd_chk(3'd2, 1'b0, 8'h00, 9'd0, 10'd0);
    rd_chk(3'd7, 1'b1, "H", 9'd2, 10'd70);
    rd_chk(3'd0, 1'b1, "A", 9'd16, 10'd0);
    two_ticks("Y", 3'd1, 9'd5, 10'd7);
    rd_chk(3'd2, 1'b1, "Y", 9'd5, 10'd7);
    rd_chk(3'd0, 1'b1, "A", 9'd18, 10'd0);
    rd_chk(3'd3, 1'b1, "D", 9'd12, 10'd30);

    // Game over after two misses, frozen slots, restart, then mid-run reset.
    do_reset();
    start_game();
    set_gen("G", 3'd1, 9'd98, 10'd1);
    tick();
    tick();
    tick();
    set_gen("H", 3'd1, 9'd98, 10'd2);
    exp_ev(1'b0, 1'b0, 1'b1, 16'd0, 8'd1);
    tick();
    tick();
    set_gen("F", 3'd1, 9'd10, 10'd33);
    exp_ev(1'b0, 1'b0, 1'b1, 16'd0, 8'd2);
    tick();
    @(negedge clk);
    @(negedge clk);
    chk("s6_game_over", 32'(bus.game_over), 32'd1);
    tick();
    tick();
    tick();
    key("F");
    rd_chk(3'd0, 1'b1, "F", 9'd10, 10'd33);
    rd_chk(3'd1, 1'b0, 8'h00, 9'd0, 10'd0);
    chk("s6_over_miss_cnt", 32'(bus.miss_cnt), 32'd2);
    chk("s6_over_hit_cnt", 32'(bus.hit_cnt), 32'd0);
    start_game();
    @(negedge clk);
    chk("s6_restart_game_over", 32'(bus.game_over), 32'd0);
    chk("s6_restart_miss_cnt", 32'(bus.miss_cnt), 32'd0);
    rd_chk(3'd0, 1'b0, 8'h00, 9'd0, 10'd0);
    set_gen("R", 3'd2, 9'd40, 10'd44);
    tick();
    rd_chk(3'd0, 1'b0, 8'h00, 9'd0, 10'd0);
    tick();
    rd_chk(3'd0, 1'b1, "R", 9'd40, 10'd44);
    exp_ev(1'b1, 1'b0, 1'b0, 16'd1, 8'd0);
    key("R");
    two_ticks("R", 3'd2, 9'd40, 10'd44);
    bus.rd_idx = 3'd0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_hit_cnt", 32'(bus.hit_cnt), 32'd0);
    chk("rst_miss_cnt", 32'(bus.miss_cnt), 32'd0);
    chk("rst_game_over", 32'(bus.game_over), 32'd0);
    chk("rst_rd", 32'({bus.rd_valid, bus.rd_ch, bus.rd_x, bus.rd_y}), 32'd0);
    rst_n = 1'b1;
    tick();
    tick();
    key("R");
    rd_chk(3'd0, 1'b0, 8'h00, 9'd0, 10'd0);
    chk("idle_game_over", 32'(bus.game_over), 32'd0);

    repeat (3) @(negedge clk);
    chk("ev_queue_drained", 32'(ev_q.size()), 32'd0);
    chk("rd_queue_drained", 32'(rd_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
